sh2_ext_bus_target: RTL and testbench



---
 rtl/sh2_ext_bus_target.sv | 141 ++++++++++++++
 tb/tb_sh2_ext_bus_target.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/sh2_ext_bus_target.sv
// SH-2 external bus responder: decodes one chip-select area and forwards it to a local memory port.
// Latency: WAIT_N low from the BS_N cycle until MEM_RDY is seen and at least MIN_WAIT CE_R cycles elapse.
// Backpressure: WAIT_N stalls the bus master; the local port stalls us by withholding MEM_RDY.
module sh2_ext_bus_target #(
    parameter int ADDR_W   = 24,
    parameter int MIN_WAIT = 1,
    parameter int RD_HOLD  = 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              CE_R,
    input  logic [26:0]       A,
    input  logic [31:0]       DO,
    output logic [31:0]       DI,
    input  logic              BS_N,
    input  logic              CS_N,
    input  logic              RD_N,
    input  logic [3:0]        WE_N,
    output logic              WAIT_N,
    output logic [ADDR_W-3:0] MEM_A,
    output logic [31:0]       MEM_DO,
    output logic [3:0]        MEM_BE,
    output logic              MEM_WE,
    output logic              MEM_RD,
    input  logic [31:0]       MEM_DI,
    input  logic              MEM_RDY
);

    typedef enum logic [2:0] {IDLE, ADDR, REQ, WAITR, DONE} state_t;

    localparam logic [2:0] MIN_WAIT_C = 3'(MIN_WAIT);
    localparam logic [7:0] RD_HOLD_C  = 8'(RD_HOLD);

    state_t      state;
    logic [2:0]  wait_cnt;
    logic [7:0]  hold_cnt;
    logic        rdy_seen;
    logic        is_rd;
    logic [31:0] rd_buf;

    logic        start;
    logic        busy;
    logic        rdy_any;
    logic [31:0] rd_now;
    logic        unused_a;

    assign start    = !CS_N && !BS_N;
    assign busy     = (state == REQ) || (state == WAITR);
    assign rdy_any  = rdy_seen || MEM_RDY;
    assign rd_now   = MEM_RDY ? MEM_DI : rd_buf;
    assign unused_a = ^{A[26:ADDR_W], A[1:0]};

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= IDLE;
            wait_cnt <= '0;
            hold_cnt <= '0;
            rdy_seen <= 1'b0;
            is_rd    <= 1'b0;
            rd_buf   <= '0;
            DI       <= '0;
            WAIT_N   <= 1'b1;
            MEM_A    <= '0;
            MEM_DO   <= '0;
            MEM_BE   <= '0;
            MEM_WE   <= 1'b0;
            MEM_RD   <= 1'b0;
        end else begin
            // Completion is latched on every clock so a pulse during CE_R=0 is not lost.
            if (busy && MEM_RDY) begin
                rdy_seen <= 1'b1;
                rd_buf   <= MEM_DI;
            end
            if (CE_R) begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            MEM_A    <= A[ADDR_W-1:2];
                            WAIT_N   <= 1'b0;
                            wait_cnt <= MIN_WAIT_C;
                            state    <= ADDR;
                        end
                    end
                    ADDR: begin
                        if (CS_N) begin
                            WAIT_N <= 1'b1;
                            state  <= IDLE;
                        end else if (WE_N != 4'hF) begin
                            MEM_DO   <= DO;
                            MEM_BE   <= ~WE_N;
                            MEM_WE   <= 1'b1;
                            is_rd    <= 1'b0;
                            rdy_seen <= 1'b0;
                            state    <= REQ;
                        end else if (!RD_N) begin
                            MEM_BE   <= 4'hF;
                            MEM_RD   <= 1'b1;
                            is_rd    <= 1'b1;
                            rdy_seen <= 1'b0;
                            state    <= REQ;
                        end
                    end
                    REQ, WAITR: begin
                        MEM_WE <= 1'b0;
                        MEM_RD <= 1'b0;
                        if (wait_cnt == 3'd0 && rdy_any) begin
                            WAIT_N   <= 1'b1;
                            if (is_rd) DI <= rd_now;
                            hold_cnt <= RD_HOLD_C;
                            rdy_seen <= 1'b0;
                            state    <= DONE;
                        end else begin
                            if (wait_cnt != 3'd0) wait_cnt <= wait_cnt - 3'd1;
                            state <= WAITR;
                        end
                    end
                    DONE: begin
                        if (RD_N || hold_cnt <= 8'd1) begin
                            DI       <= '0;
                            hold_cnt <= '0;
                        end else begin
                            hold_cnt <= hold_cnt - 8'd1;
                        end
                        // Back-to-back cycle: the next BS_N is accepted without an IDLE gap.
                        if (start) begin
                            MEM_A    <= A[ADDR_W-1:2];
                            WAIT_N   <= 1'b0;
                            wait_cnt <= MIN_WAIT_C;
                            state    <= ADDR;
                        end else if (CS_N) begin
                            DI    <= '0;
                            state <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sh2_ext_bus_target.sv
// Directed bench for sh2_ext_bus_target: default instance (MIN_WAIT=1) plus a MIN_WAIT=4 instance.
module tb_sh2_ext_bus_target;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ce_r = 1'b1;
    logic [26:0] a = '0;
    logic [31:0] do_w = '0;
    logic        bs_n = 1'b1, cs_n = 1'b1, cs4_n = 1'b1, rd_n = 1'b1;
    logic [3:0]  we_n = 4'hF;
    logic [31:0] mem_di = '0;
    logic        mem_rdy = 1'b0;

    logic [31:0] di, mem_do, di4, mem_do4;
    logic        wait_n, mem_we, mem_rd, wait4_n, mem_we4, mem_rd4;
    logic [21:0] mem_a, mem_a4;
    logic [3:0]  mem_be, mem_be4;

    int n_total = 0, n_pass = 0, n_fail = 0;

    always #5 clk = ~clk;

    sh2_ext_bus_target u_dut (
        .CLK(clk), .RST(rst), .CE_R(ce_r), .A(a), .DO(do_w), .DI(di),
        .BS_N(bs_n), .CS_N(cs_n), .RD_N(rd_n), .WE_N(we_n), .WAIT_N(wait_n),
        .MEM_A(mem_a), .MEM_DO(mem_do), .MEM_BE(mem_be), .MEM_WE(mem_we),
        .MEM_RD(mem_rd), .MEM_DI(mem_di), .MEM_RDY(mem_rdy)
    );

    sh2_ext_bus_target #(.MIN_WAIT(4)) u_dut4 (
        .CLK(clk), .RST(rst), .CE_R(ce_r), .A(a), .DO(do_w), .DI(di4),
        .BS_N(bs_n), .CS_N(cs4_n), .RD_N(rd_n), .WE_N(we_n), .WAIT_N(wait4_n),
        .MEM_A(mem_a4), .MEM_DO(mem_do4), .MEM_BE(mem_be4), .MEM_WE(mem_we4),
        .MEM_RD(mem_rd4), .MEM_DI(mem_di), .MEM_RDY(mem_rdy)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #12 rst = 1'b0;
        step();
        check("rst_di", 64'(di), 64'h0);
        check("rst_wait_n", 64'(wait_n), 64'h1);
        check("rst_mem_a", 64'(mem_a), 64'h0);
        check("rst_mem_do", 64'(mem_do), 64'h0);
        check("rst_mem_be", 64'(mem_be), 64'h0);
        check("rst_mem_we", 64'(mem_we), 64'h0);
        check("rst_mem_rd", 64'(mem_rd), 64'h0);

        // Read, MIN_WAIT=1, MEM_RDY three cycles after MEM_RD
        a = 27'h0123456; cs_n = 1'b0; bs_n = 1'b0;
        step();
        check("rd_wait1", 64'(wait_n), 64'h0);
        check("rd_mem_a", 64'(mem_a), 64'h048D15);
        bs_n = 1'b1; rd_n = 1'b0;
        step();
        check("rd_wait2", 64'(wait_n), 64'h0);
        check("rd_mem_rd", 64'(mem_rd), 64'h1);
        check("rd_mem_be", 64'(mem_be), 64'hF);
        step();
        check("rd_wait3", 64'(wait_n), 64'h0);
        check("rd_mem_rd_pulse", 64'(mem_rd), 64'h0);
        step();
        check("rd_wait4", 64'(wait_n), 64'h0);
        step();
        check("rd_wait5", 64'(wait_n), 64'h0);
        mem_rdy = 1'b1; mem_di = 32'hDEADBEEF;
        step();
        mem_rdy = 1'b0;
        check("rd_release", 64'(wait_n), 64'h1);
        check("rd_di", 64'(di), 64'hDEADBEEF);
        rd_n = 1'b1; cs_n = 1'b1;
        step();
        check("rd_di_clear", 64'(di), 64'h0);

        // Byte write
        a = 27'h0000010; cs_n = 1'b0; bs_n = 1'b0;
        step();
        bs_n = 1'b1; we_n = 4'b1101; do_w = 32'h00AB0000;
        step();
        check("wr_mem_we", 64'(mem_we), 64'h1);
        check("wr_mem_be", 64'(mem_be), 64'h2);
        check("wr_mem_do", 64'(mem_do), 64'h00AB0000);
        check("wr_mem_rd", 64'(mem_rd), 64'h0);
        step();
        check("wr_mem_we_pulse", 64'(mem_we), 64'h0);
        check("wr_wait", 64'(wait_n), 64'h0);
        mem_rdy = 1'b1;
        step();
        mem_rdy = 1'b0;
        check("wr_release", 64'(wait_n), 64'h1);
        check("wr_mem_we_once", 64'(mem_we), 64'h0);
        we_n = 4'hF; cs_n = 1'b1;
        step();

        // MIN_WAIT=4 with immediate MEM_RDY
        cs4_n = 1'b0; bs_n = 1'b0;
        step();
        check("mw4_wait1", 64'(wait4_n), 64'h0);
        bs_n = 1'b1; rd_n = 1'b0;
        step();
        check("mw4_mem_rd", 64'(mem_rd4), 64'h1);
        mem_rdy = 1'b1; mem_di = 32'h12345678;
        step();
        mem_rdy = 1'b0;
        check("mw4_wait3", 64'(wait4_n), 64'h0);
        for (int i = 4; i <= 6; i++) begin
            step();
            check($sformatf("mw4_wait%0d", i), 64'(wait4_n), 64'h0);
        end
        step();
        check("mw4_release", 64'(wait4_n), 64'h1);
        check("mw4_di", 64'(di4), 64'h12345678);
        rd_n = 1'b1; cs4_n = 1'b1;
        step();

        // Abort in ADDR, then CS_N without BS_N must be ignored
        cs_n = 1'b0; bs_n = 1'b0;
        step();
        check("ab_wait_low", 64'(wait_n), 64'h0);
        bs_n = 1'b1; cs_n = 1'b1;
        step();
        check("ab_wait_high", 64'(wait_n), 64'h1);
        check("ab_no_req", 64'({mem_rd, mem_we}), 64'h0);
        cs_n = 1'b0; rd_n = 1'b0;
        step();
        check("ab_idle_wait", 64'(wait_n), 64'h1);
        check("ab_idle_no_rd", 64'(mem_rd), 64'h0);
        cs_n = 1'b1; rd_n = 1'b1;
        step();

        // Back-to-back read then write
        a = 27'h0000100; cs_n = 1'b0; bs_n = 1'b0;
        step();
        bs_n = 1'b1; rd_n = 1'b0;
        step();
        check("bb_mem_rd", 64'(mem_rd), 64'h1);
        mem_rdy = 1'b1; mem_di = 32'hCAFEF00D;
        step();
        mem_rdy = 1'b0;
        step();
        check("bb_rd_release", 64'(wait_n), 64'h1);
        check("bb_rd_di", 64'(di), 64'hCAFEF00D);
        rd_n = 1'b1; bs_n = 1'b0; a = 27'h0000200;
        step();
        check("bb_restart_wait", 64'(wait_n), 64'h0);
        check("bb_restart_mem_a", 64'(mem_a), 64'h80);
        check("bb_di_clear", 64'(di), 64'h0);
        bs_n = 1'b1; we_n = 4'h0; do_w = 32'h11223344;
        step();
        check("bb_mem_we", 64'(mem_we), 64'h1);
        check("bb_mem_be", 64'(mem_be), 64'hF);
        check("bb_mem_do", 64'(mem_do), 64'h11223344);
        mem_rdy = 1'b1;
        step();
        mem_rdy = 1'b0;
        check("bb_mem_we_pulse", 64'(mem_we), 64'h0);
        step();
        check("bb_wr_release", 64'(wait_n), 64'h1);
        cs_n = 1'b1; we_n = 4'hF;
        step();

        // Reset during WAITR, then a stray MEM_RDY
        a = 27'h0000040; cs_n = 1'b0; bs_n = 1'b0;
        step();
        bs_n = 1'b1; rd_n = 1'b0;
        step();
        step();
        rst = 1'b1;
        #2;
        check("mr_wait_n", 64'(wait_n), 64'h1);
        check("mr_mem_rd", 64'(mem_rd), 64'h0);
        check("mr_mem_a", 64'(mem_a), 64'h0);
        check("mr_mem_be", 64'(mem_be), 64'h0);
        rst = 1'b0; cs_n = 1'b1; rd_n = 1'b1;
        mem_rdy = 1'b1; mem_di = 32'hBAD0BAD0;
        step();
        mem_rdy = 1'b0;
        check("mr_stray_di", 64'(di), 64'h0);
        check("mr_stray_wait", 64'(wait_n), 64'h1);

        // Next access, with MEM_RDY arriving while CE_R=0
        a = 27'h0000044; cs_n = 1'b0; bs_n = 1'b0;
        step();
        check("nx_mem_a", 64'(mem_a), 64'h11);
        bs_n = 1'b1; rd_n = 1'b0;
        step();
        check("nx_mem_rd", 64'(mem_rd), 64'h1);
        step();
        ce_r = 1'b0; mem_rdy = 1'b1; mem_di = 32'h5A5A5A5A;
        step();
        mem_rdy = 1'b0;
        check("nx_ce_hold", 64'(wait_n), 64'h0);
        ce_r = 1'b1;
        step();
        check("nx_release", 64'(wait_n), 64'h1);
        check("nx_di", 64'(di), 64'h5A5A5A5A);
        rd_n = 1'b1; cs_n = 1'b1;
        step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
